// File: rtl/bcd_disp_pkg.sv
// Shared constants for the multiplexed BCD display scanner.
// Segment words are active-low, with bit0 = a through bit6 = g.
package bcd_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    // Entries 0..9 are the decimal digits; A..F are not BCD, so they show a dash.
    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH
    };

endpackage

// File: rtl/bcd_seg_lut.sv
// Combinational nibble to active-low seven-segment decode.
module bcd_seg_lut
    import bcd_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_TABLE[nibble];
    end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed BCD display driver. New values are double-buffered and are
// applied only at a frame wrap, so a frame never mixes digits from two values.
module bcd_display_scanner
    import bcd_disp_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [4*DIGITS-1:0]   BCD,
    input  logic                  LOAD_VALID,
    output logic                  LOAD_READY,
    input  logic                  BLANK_LZ,
    input  logic                  BLANK,
    output logic [6:0]            HEX,
    output logic [DIGITS-1:0]     AN,
    output logic                  FRAME
);

    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    idx;
    logic [4*DIGITS-1:0] active;
    logic [4*DIGITS-1:0] pending;
    logic                pend_valid;
    logic [6:0]          hex_q;
    logic [DIGITS-1:0]   an_q;
    logic                frame_q;

    logic                cnt_last;
    logic                wrap;
    logic [3:0]          nibble;
    logic [6:0]          seg;
    logic [DIGITS-1:0]   an_sel;
    logic                hi_zero;
    logic                suppress;

    assign cnt_last = (cnt == CNT_LAST);
    assign wrap     = cnt_last && (idx == IDX_LAST);

    // hi_zero: the selected digit and every digit above it are zero.
    always_comb begin
        nibble  = '0;
        an_sel  = '1;
        hi_zero = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                nibble    = active[4*k +: 4];
                an_sel[k] = 1'b0;
            end
            if ((IDX_W'(k) >= idx) && (active[4*k +: 4] != 4'd0)) begin
                hi_zero = 1'b0;
            end
        end
        suppress = BLANK_LZ && (idx != '0) && hi_zero;
    end

    bcd_seg_lut u_lut (
        .nibble (nibble),
        .seg    (seg)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt        <= '0;
            idx        <= '0;
            active     <= '0;
            pending    <= '0;
            pend_valid <= 1'b0;
            hex_q      <= SEG_BLANK;
            an_q       <= '1;
            frame_q    <= 1'b0;
        end else begin
            if (cnt_last) begin
                cnt <= '0;
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end

            // pend_valid=0 in a wrap cycle lets that cycle's capture wait a full frame.
            if (pend_valid && wrap) begin
                active     <= pending;
                pend_valid <= 1'b0;
            end else if (LOAD_VALID && !pend_valid) begin
                pending    <= BCD;
                pend_valid <= 1'b1;
            end

            frame_q <= (cnt == '0) && (idx == '0);

            if (BLANK) begin
                hex_q <= SEG_BLANK;
                an_q  <= '1;
            end else begin
                hex_q <= suppress ? SEG_BLANK : seg;
                an_q  <= an_sel;
            end
        end
    end

    assign LOAD_READY = !pend_valid;
    assign HEX        = hex_q;
    assign AN         = an_q;
    assign FRAME      = frame_q;

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Directed bench for bcd_display_scanner with DIGITS=4, SCAN_DIV=4 (16-cycle frame).
module tb_bcd_display_scanner;

    logic        CLK;
    logic        RST;
    logic [15:0] BCD;
    logic        LOAD_VALID;
    logic        LOAD_READY;
    logic        BLANK_LZ;
    logic        BLANK;
    logic [6:0]  HEX;
    logic [3:0]  AN;
    logic        FRAME;

    int total = 0;
    int bad   = 0;

    bcd_display_scanner #(.DIGITS(4), .SCAN_DIV(4)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .BCD        (BCD),
        .LOAD_VALID (LOAD_VALID),
        .LOAD_READY (LOAD_READY),
        .BLANK_LZ   (BLANK_LZ),
        .BLANK      (BLANK),
        .HEX        (HEX),
        .AN         (AN),
        .FRAME      (FRAME)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [15:0]     bcd;
        logic            lz;
        logic [3:0][6:0] exp;   // exp[d] is the HEX word expected on digit d
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    // Called on the FRAME cycle; leaves off on the next frame's FRAME cycle.
    task automatic check_frame(input string tag, input logic [3:0][6:0] exp);
        for (int d = 0; d < 4; d++) begin
            for (int c = 0; c < 4; c++) begin
                logic [3:0] an_exp;
                an_exp    = 4'hF;
                an_exp[d] = 1'b0;
                chk(tag, {FRAME, AN, HEX}, {(d == 0 && c == 0), an_exp, exp[d]});
                tick();
            end
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!LOAD_READY && n < 40) begin
            tick();
            n++;
        end
        chk("ready_wait", LOAD_READY, 1);
    endtask

    task automatic wait_frame();
        int n = 0;
        while (!FRAME && n < 40) begin
            tick();
            n++;
        end
        chk("frame_wait", FRAME, 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk(tag, {FRAME, LOAD_READY, AN, HEX}, {1'b0, 1'b1, 4'hF, 7'h7F});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{16'h1234, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19}};
        vecs[1] = '{16'h0007, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h78}};
        vecs[2] = '{16'h0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{16'h00A0, 1'b0, {7'h40, 7'h40, 7'h3F, 7'h40}};
        vecs[4] = '{16'h8090, 1'b1, {7'h00, 7'h40, 7'h10, 7'h40}};
        vecs[5] = '{16'h0A00, 1'b1, {7'h7F, 7'h3F, 7'h40, 7'h40}};
        vecs[6] = '{16'h5678, 1'b0, {7'h12, 7'h02, 7'h78, 7'h00}};

        RST        = 1'b1;
        BCD        = '0;
        LOAD_VALID = 1'b0;
        BLANK_LZ   = 1'b0;
        BLANK      = 1'b0;

        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            chk_reset_outputs("reset_hold");
        end
        RST = 1'b0;
        #1;
        chk_reset_outputs("reset_release");
        tick();
        check_frame("first_frame_zero", {7'h40, 7'h40, 7'h40, 7'h40});

        for (int i = 0; i < 7; i++) begin
            wait_ready();
            BLANK_LZ   = vecs[i].lz;
            BCD        = vecs[i].bcd;
            LOAD_VALID = 1'b1;
            tick();
            LOAD_VALID = 1'b0;
            chk("ready_low_after_load", LOAD_READY, 0);
            wait_ready();
            wait_frame();
            check_frame("vector_frame", vecs[i].exp);
        end

        // BLANK for 5 edges starting on a FRAME cycle; FRAME still lands 16 later.
        BLANK_LZ = 1'b0;
        BLANK    = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            tick();
            if (t <= 5) chk("blank_dark", {AN, HEX}, {4'hF, 7'h7F});
            if (t == 5) BLANK = 1'b0;
            chk("blank_frame_cadence", FRAME, (t == 16));
        end
        chk("blank_released", {AN, HEX}, {4'b1110, 7'h00});

        // Back-pressure: 16'h2222 offered while busy must be dropped.
        BCD        = 16'h1111;
        LOAD_VALID = 1'b1;
        tick();
        chk("bp_ready_low", LOAD_READY, 0);
        BCD = 16'h2222;
        repeat (12) tick();
        chk("bp_ready_still_low", LOAD_READY, 0);
        LOAD_VALID = 1'b0;
        repeat (3) tick();
        chk("bp_frame", FRAME, 1);
        check_frame("bp_shows_1111", {7'h79, 7'h79, 7'h79, 7'h79});
        chk("bp_ready_high", LOAD_READY, 1);

        // Capture sampled on the wrap edge itself waits one full frame.
        repeat (14) tick();
        chk("wrap_ready_before", LOAD_READY, 1);
        BCD        = 16'h3333;
        LOAD_VALID = 1'b1;
        tick();
        LOAD_VALID = 1'b0;
        chk("wrap_capture_ready_low", LOAD_READY, 0);
        tick();
        check_frame("wrap_old_value", {7'h79, 7'h79, 7'h79, 7'h79});
        chk("wrap_ready_after", LOAD_READY, 1);
        check_frame("wrap_new_value", {7'h30, 7'h30, 7'h30, 7'h30});

        // Reset while 16'h9999 is pending: it must never reach the display.
        BCD        = 16'h9999;
        LOAD_VALID = 1'b1;
        tick();
        LOAD_VALID = 1'b0;
        chk("rst_pending_ready_low", LOAD_READY, 0);
        repeat (4) tick();
        RST = 1'b1;
        tick();
        chk_reset_outputs("midrst_hold");
        tick();
        chk_reset_outputs("midrst_hold");
        RST = 1'b0;
        #1;
        chk_reset_outputs("midrst_release");
        tick();
        check_frame("midrst_zero_1", {7'h40, 7'h40, 7'h40, 7'h40});
        check_frame("midrst_zero_2", {7'h40, 7'h40, 7'h40, 7'h40});
        chk("midrst_ready", LOAD_READY, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_display_scanner.md
BCD_DISPLAY_SCANNER -- requirements
Module: bcd_display_scanner

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of BCD digits and display positions, range 1..8.
REQ-002 SHALL have parameter SCAN_DIV, default 50000: CLK cycles each digit stays selected, minimum 2.
REQ-003 SHALL have port CLK  input  1  sole clock; all state changes on the rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port BCD  input  4*DIGITS  packed BCD value; nibble k is digit k, and digit 0 is the least significant.
REQ-006 SHALL have port LOAD_VALID  input  1  BCD is offered for capture.
REQ-007 SHALL have port LOAD_READY  output  1  the block can accept BCD this cycle.
REQ-008 SHALL have port BLANK_LZ  input  1  enables leading-zero suppression.
REQ-009 SHALL have port BLANK  input  1  switches all digits off.
REQ-010 SHALL have port HEX  output  7  active-low segments, registered; bit0=a through bit6=g.
REQ-011 SHALL have port AN  output  DIGITS  active-low digit select, registered, one-hot-low.
REQ-012 SHALL have port FRAME  output  1  one-cycle pulse when the scan wraps to digit 0.

Function
REQ-013 SHALL count scan cycles 0..SCAN_DIV-1, and at count SCAN_DIV-1 SHALL reset the count and advance the digit index, wrapping DIGITS-1 to 0.
REQ-014 SHALL register HEX and AN from the current index and the active register, with 1 cycle of latency from an index change.
REQ-015 SHALL capture BCD into the pending register on LOAD_VALID&LOAD_READY and SHALL then drive LOAD_READY low on the following cycle.
REQ-016 At each wrap (index DIGITS-1 to 0) with pending valid, SHALL copy pending to active, clear pending valid, and raise LOAD_READY in the next cycle.
REQ-017 A capture in the wrap cycle itself SHALL go to pending and SHALL be applied at the next wrap, so the display never tears mid-frame.
REQ-018 LOAD_VALID while LOAD_READY=0 SHALL be ignored, with no capture and no error.
REQ-019 Decode: digits 0..9 SHALL use standard active-low patterns (0=7'h40, 1=7'h79, 4=7'h19, 7=7'h78, 8=7'h00); nibbles A..F SHALL show a dash, 7'h3F.
REQ-020 With BLANK_LZ=1, zero digits above the most significant non-zero digit SHALL output HEX=7'h7F with AN still selected; digit 0 SHALL never be suppressed.
REQ-021 With BLANK=1, AN SHALL be all ones and HEX SHALL be 7'h7F from the next cycle; the scan counter and handshake SHALL continue unaffected.
REQ-022 FRAME SHALL assert for exactly one cycle, in the same cycle AN first selects digit 0 of a new frame.
REQ-023 With DIGITS=1, the index SHALL stay 0 and FRAME SHALL pulse every SCAN_DIV cycles.

Reset
REQ-024 RST SHALL be sampled only at the CLK edge and SHALL take priority over all other inputs.
REQ-025 While RST=1 and on the cycle after release, the following SHALL hold: HEX=7'h7F, AN all ones, FRAME=0, LOAD_READY=1, index=0, scan count=0, active=0, pending valid=0.
REQ-026 RST asserted mid-frame or mid-handshake SHALL discard pending data without applying it.
REQ-027 The first scan after reset SHALL select digit 0, showing active value 0.

Structure
REQ-028 Package bcd_disp_pkg SHALL hold the constants SEG_BLANK=7'h7F and SEG_DASH=7'h3F, the 16-entry segment table, and the segment index constants SEG_A..SEG_G.
REQ-029 The nibble-to-segment decode SHALL be a combinational sub-module, bcd_seg_lut (4-bit in, 7-bit active-low out), instantiated once on the selected nibble.
REQ-030 Blanking muxes, the handshake and the scan counter SHALL sit in bcd_display_scanner.

Verification (DIGITS=4, SCAN_DIV=4)
REQ-031 Reset: with RST high for 3 cycles, the bench SHALL require HEX=7'h7F, AN=4'hF, LOAD_READY=1 and FRAME=0 throughout and one cycle after release.
REQ-032 Load and scan: load 16'h1234 -> LOAD_READY low until the next wrap; then, per digit for 4 cycles each, AN=1110/HEX=7'h19, 1101/7'h30, 1011/7'h24, 0111/7'h79, with FRAME high in the AN=1110 first cycle.
REQ-033 Leading-zero blanking: BLANK_LZ=1 with 16'h0007 -> digits 3..1 HEX=7'h7F and digit 0 HEX=7'h78; value 16'h0000 -> only digit 0 lit, with 7'h40.
REQ-034 Invalid digit and BLANK: 16'h00A0 -> digit 1 HEX=7'h3F; BLANK=1 for 5 cycles -> AN=4'hF, with FRAME cadence unchanged.
REQ-035 Back-pressure and wrap collision: assert LOAD_VALID with 16'h1111 and hold it with 16'h2222 -> 16'h2222 is ignored while LOAD_READY=0; a capture exactly on the wrap cycle is applied one full frame (16 cycles) later.
REQ-036 Reset mid-handshake: RST during pending 16'h9999 -> display stays all 7'h7F, then value 0, and 16'h9999 is never shown.
